// File: rtl/globals_sv.sv
// Project-wide sizing constants and shared state types.
package globals_sv;
    localparam int unsigned N      = 4;
    localparam int unsigned W      = 8;
    localparam int unsigned CLOG2M = 4;
    localparam int unsigned CLOG2W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HALF = 1'b1
    } res_wb_state_t;
endpackage

// File: rtl/res_wb.sv
// Result write-back packer: joins two half-line strobes into one full-line
// write to the even or odd bank, with protocol error tracking.
module res_wb #(
    parameter int unsigned N  = globals_sv::N,
    parameter int unsigned W  = globals_sv::W,
    parameter int unsigned AW = globals_sv::CLOG2M + globals_sv::CLOG2W
) (
    input  logic                ck,
    input  logic                rst,
    input  logic                i_clr,
    input  logic                i_data_wr,
    input  logic                i_data_wrh_l_n,
    input  logic [N*(W/2)-1:0]  i_data,
    input  logic                i_ev_odd_n,
    input  logic [AW-1:0]       i_even_addr,
    input  logic [AW-1:0]       i_odd_addr,
    output logic                o_even_we,
    output logic                o_odd_we,
    output logic [AW-1:0]       o_even_addr,
    output logic [AW-1:0]       o_odd_addr,
    output logic [N*W-1:0]      o_even_wdata,
    output logic [N*W-1:0]      o_odd_wdata,
    output logic                o_busy,
    output logic                o_err,
    output logic [15:0]         o_lines
);
    import globals_sv::*;

    localparam int unsigned HW = N * (W / 2);
    localparam int unsigned LW = N * W;

    res_wb_state_t state_q, state_d;

    logic [HW-1:0] held_q,      held_d;
    logic          held_odd_q,  held_odd_d;
    logic [AW-1:0] held_addr_q, held_addr_d;

    logic          even_we_q,    even_we_d;
    logic          odd_we_q,     odd_we_d;
    logic [AW-1:0] even_addr_q,  even_addr_d;
    logic [AW-1:0] odd_addr_q,   odd_addr_d;
    logic [LW-1:0] even_wdata_q, even_wdata_d;
    logic [LW-1:0] odd_wdata_q,  odd_wdata_d;
    logic          busy_q,       busy_d;
    logic          err_q,        err_d;
    logic [15:0]   lines_q,      lines_d;

    logic [AW-1:0] sel_addr;
    logic          match;

    assign sel_addr = i_ev_odd_n ? i_odd_addr : i_even_addr;
    assign match    = (i_ev_odd_n == held_odd_q) && (sel_addr == held_addr_q);

    always_comb begin
        state_d      = state_q;
        held_d       = held_q;
        held_odd_d   = held_odd_q;
        held_addr_d  = held_addr_q;
        even_we_d    = 1'b0;
        odd_we_d     = 1'b0;
        even_addr_d  = even_addr_q;
        odd_addr_d   = odd_addr_q;
        even_wdata_d = even_wdata_q;
        odd_wdata_d  = odd_wdata_q;
        err_d        = err_q;
        lines_d      = lines_q;

        // Clear beats any strobe in the same cycle; bank outputs already
        // registered last cycle are left to complete.
        if (i_clr) begin
            state_d     = IDLE;
            held_d      = '0;
            held_odd_d  = 1'b0;
            held_addr_d = '0;
            err_d       = 1'b0;
            lines_d     = '0;
        end else if (i_data_wr) begin
            unique case (state_q)
                IDLE: begin
                    if (!i_data_wrh_l_n) begin
                        held_d      = i_data;
                        held_odd_d  = i_ev_odd_n;
                        held_addr_d = sel_addr;
                        state_d     = HALF;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                HALF: begin
                    if (!i_data_wrh_l_n) begin
                        err_d       = 1'b1;
                        held_d      = i_data;
                        held_odd_d  = i_ev_odd_n;
                        held_addr_d = sel_addr;
                    end else if (match) begin
                        if (held_odd_q) begin
                            odd_we_d    = 1'b1;
                            odd_addr_d  = held_addr_q;
                            odd_wdata_d = {held_q, i_data};
                        end else begin
                            even_we_d    = 1'b1;
                            even_addr_d  = held_addr_q;
                            even_wdata_d = {held_q, i_data};
                        end
                        if (lines_q != 16'hFFFF) begin
                            lines_d = lines_q + 16'd1;
                        end
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == HALF);
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q      <= IDLE;
            held_q       <= '0;
            held_odd_q   <= 1'b0;
            held_addr_q  <= '0;
            even_we_q    <= 1'b0;
            odd_we_q     <= 1'b0;
            even_addr_q  <= '0;
            odd_addr_q   <= '0;
            even_wdata_q <= '0;
            odd_wdata_q  <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            lines_q      <= '0;
        end else begin
            state_q      <= state_d;
            held_q       <= held_d;
            held_odd_q   <= held_odd_d;
            held_addr_q  <= held_addr_d;
            even_we_q    <= even_we_d;
            odd_we_q     <= odd_we_d;
            even_addr_q  <= even_addr_d;
            odd_addr_q   <= odd_addr_d;
            even_wdata_q <= even_wdata_d;
            odd_wdata_q  <= odd_wdata_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            lines_q      <= lines_d;
        end
    end

    assign o_even_we    = even_we_q;
    assign o_odd_we     = odd_we_q;
    assign o_even_addr  = even_addr_q;
    assign o_odd_addr   = odd_addr_q;
    assign o_even_wdata = even_wdata_q;
    assign o_odd_wdata  = odd_wdata_q;
    assign o_busy       = busy_q;
    assign o_err        = err_q;
    assign o_lines      = lines_q;
endmodule
